// File: rtl/divider_sequencer.sv
// ---------------------------------------------------------------------------
// divider_sequencer
//   Iterative restoring unsigned divider controller. Holds the quotient and
//   remainder registers and a step counter, and drives one external
//   (WIDTH+1)-bit adder as a trial subtractor once per cycle. One quotient
//   bit is retired per RUN cycle; divide-by-zero short-circuits to DONE.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   Start      in   1        request, sampled only in IDLE or DONE
//   Dividend   in   WIDTH    captured on accepted Start
//   Divisor    in   WIDTH    captured on accepted Start
//   AddA       out  WIDTH+1  adder operand A = {Rem, Quo msb}
//   AddB       out  WIDTH+1  adder operand B = ~{0, divisor}
//   AddCin     out  1        constant 1 (subtract)
//   AddSum     in   WIDTH+1  adder sum
//   AddCout    in   1        adder carry out, 1 = trial difference >= 0
//   Busy       out  1        high while RUN
//   Done       out  1        one-cycle result-valid pulse
//   DivZero    out  1        divisor was zero on last accepted Start
//   Quotient   out  WIDTH    result quotient
//   Remainder  out  WIDTH    result remainder
// ---------------------------------------------------------------------------
module divider_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH:0]   AddA,
  output logic [WIDTH:0]   AddB,
  output logic             AddCin,
  input  logic [WIDTH:0]   AddSum,
  input  logic             AddCout,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  // Divisor is stored already complemented so AddB is a pure register output
  // and reads 0 out of reset.
  logic [WIDTH:0]   r_divn;
  logic             r_divzero;
  logic             w_accept;
  logic             w_div_is_zero;
  logic             w_last;
  logic             w_unused_sum_msb;

  // The remainder invariant (Rem < divisor) keeps every accepted difference
  // inside WIDTH bits, so the adder's top sum bit carries no information.
  assign w_unused_sum_msb = AddSum[WIDTH];

  assign w_div_is_zero = (Divisor == '0);
  assign w_accept      = Start && (r_state != S_RUN);
  assign w_last        = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          w_state_nxt = w_div_is_zero ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divn    <= '0;
      r_divzero <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_divn    <= ~{1'b0, Divisor};
      r_divzero <= w_div_is_zero;
      if (w_div_is_zero) begin
        r_quo <= '1;
        r_rem <= Dividend;
      end else begin
        r_quo <= Dividend;
        r_rem <= '0;
      end
    end else if (r_state == S_RUN) begin
      // Shift the next dividend bit into the partial remainder; keep the
      // trial difference only when it did not go negative.
      r_quo <= {r_quo[WIDTH-2:0], AddCout};
      r_rem <= AddCout ? AddSum[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign AddA      = {r_rem, r_quo[WIDTH-1]};
  assign AddB      = r_divn;
  assign AddCin    = 1'b1;
  assign Busy      = (r_state == S_RUN);
  assign Done      = (r_state == S_DONE);
  assign DivZero   = r_divzero;
  assign Quotient  = r_quo;
  assign Remainder = r_rem;

endmodule

// File: tb/tb_divider_sequencer.sv
module tb_divider_sequencer;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic           Start;
  logic [W-1:0]   Dividend;
  logic [W-1:0]   Divisor;
  logic [W:0]     AddA;
  logic [W:0]     AddB;
  logic           AddCin;
  logic [W:0]     AddSum;
  logic           AddCout;
  logic           Busy;
  logic           Done;
  logic           DivZero;
  logic [W-1:0]   Quotient;
  logic [W-1:0]   Remainder;
  logic [W+1:0]   sum_full;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  divider_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .AddA      (AddA),
    .AddB      (AddB),
    .AddCin    (AddCin),
    .AddSum    (AddSum),
    .AddCout   (AddCout),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero),
    .Quotient  (Quotient),
    .Remainder (Remainder)
  );

  // External (W+1)-bit adder.
  assign sum_full = {1'b0, AddA} + {1'b0, AddB} + {{(W+1){1'b0}}, AddCin};
  assign AddSum   = sum_full[W:0];
  assign AddCout  = sum_full[W+1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first cycle after the accepting edge.
  // Returns cycles until Done (1 = cycle right after accept) and Busy count.
  // With inj set, a Start with other operands is pulsed at RUN cycle 10.
  task automatic wait_done(input bit inj, output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    forever begin
      n++;
      if (Busy) nbusy++;
      if (Done) break;
      if (n >= 100) begin
        chk("done_timeout", 64'(Done), 64'd1);
        break;
      end
      if (inj && n == 10) begin
        Start = 1'b1; Dividend = 32'd50; Divisor = 32'd3;
      end else if (inj && n == 11) begin
        Start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inj, output int n, output int nbusy);
    @(negedge clk);
    Start = 1'b1; Dividend = a; Divisor = b;
    @(negedge clk);
    Start = 1'b0;
    wait_done(inj, n, nbusy);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] q,
                           input logic [W-1:0] r, input logic dz);
    chk({tag, "_q"},  64'(Quotient),  64'(q));
    chk({tag, "_r"},  64'(Remainder), 64'(r));
    chk({tag, "_dz"}, 64'(DivZero),   64'(dz));
  endtask

  initial begin
    int n;
    int nb;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;

    rst_n = 1'b0; Start = 1'b0; Dividend = '0; Divisor = '0;
    #1;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_q",    64'(Quotient), 64'd0);
    chk("rst_r",    64'(Remainder), 64'd0);
    chk("rst_dz",   64'(DivZero), 64'd0);
    chk("rst_adda", 64'(AddA), 64'd0);
    chk("rst_addb", 64'(AddB), 64'd0);
    chk("rst_cin",  64'(AddCin), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 100 / 7
    do_div(32'd100, 32'd7, 1'b0, n, nb);
    chk("d100_lat",  64'(n),  64'd33);
    chk("d100_busy", 64'(nb), 64'd32);
    check_res("d100", 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    chk("idle_done", 64'(Done), 64'd0);
    chk("idle_busy", 64'(Busy), 64'd0);
    chk("idle_hold_q", 64'(Quotient), 64'd14);

    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, n, nb);
    check_res("max_by1", 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_div(32'd3, 32'd10, 1'b0, n, nb);
    check_res("small", 32'd0, 32'd3, 1'b0);
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n, nb);
    check_res("max_max", 32'd1, 32'd0, 1'b0);

    // divide by zero
    do_div(32'd5, 32'd0, 1'b0, n, nb);
    chk("dz_lat",  64'(n),  64'd1);
    chk("dz_busy", 64'(nb), 64'd0);
    check_res("dz", 32'hFFFF_FFFF, 32'd5, 1'b1);
    // DivZero clears on the next accept
    do_div(32'd9, 32'd3, 1'b0, n, nb);
    check_res("after_dz", 32'd3, 32'd0, 1'b0);

    // Start during RUN is ignored
    do_div(32'd100, 32'd7, 1'b1, n, nb);
    chk("inj_lat", 64'(n), 64'd33);
    check_res("inj", 32'd14, 32'd2, 1'b0);

    // Start held through DONE: back-to-back accept
    @(negedge clk);
    Start = 1'b1; Dividend = 32'd100; Divisor = 32'd7;
    @(negedge clk);
    wait_done(1'b0, n, nb);
    check_res("b2b_first", 32'd14, 32'd2, 1'b0);
    Dividend = 32'd3000; Divisor = 32'd7;
    @(negedge clk);
    chk("b2b_busy", 64'(Busy), 64'd1);
    chk("b2b_done", 64'(Done), 64'd0);
    Start = 1'b0;
    wait_done(1'b0, n, nb);
    chk("b2b_lat", 64'(n), 64'd33);
    check_res("b2b_second", 32'd428, 32'd4, 1'b0);

    // Reset in the middle of RUN
    @(negedge clk);
    Start = 1'b1; Dividend = 32'd100; Divisor = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(Busy), 64'd0);
    chk("mrst_q",    64'(Quotient), 64'd0);
    chk("mrst_r",    64'(Remainder), 64'd0);
    chk("mrst_adda", 64'(AddA), 64'd0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) n++;
    end
    chk("mrst_nodone", 64'(n), 64'd0);
    rst_n = 1'b1;
    do_div(32'd100, 32'd7, 1'b0, n, nb);
    chk("mrst_lat", 64'(n), 64'd33);
    check_res("mrst_after", 32'd14, 32'd2, 1'b0);

    // Random pairs against / and %
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = 32'd1;
        1: b = a + 32'($urandom_range(1, 1000));
        2: b = 32'($urandom_range(1, 65535));
        default: b = $urandom;
      endcase
      if (b == 0) b = 32'd1;
      eq = a / b;
      er = a % b;
      do_div(a, b, 1'b0, n, nb);
      chk("rnd_q", 64'(Quotient), 64'(eq));
      chk("rnd_r", 64'(Remainder), 64'(er));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
